// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode
//   Instruction-decode stage between fetch and execute. Two-entry pipeline:
//   slot A is the IF/ID latch and holds the raw (pc, command) pair. Slot B is
//   the ID/EX register and holds the fully decoded instruction with its
//   operand values. Both sides use a valid/ready handshake. A flush discards
//   everything in flight.
//
//   Optional feature: define DECODE_LOAD_STALL_EN to hold an instruction in A
//   while the load sitting in B writes one of the registers it reads. Without
//   the macro no interlock is applied, and execute must resolve load-use.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   flush                    drop A, B and any same-cycle input
//   in_valid / in_ready      fetch handshake (in_ready is combinational
//                            from out_ready)
//   in_pc, in_command        instruction address and word
//   rs_addr, rt_addr         regfile read addresses (0 when A is empty)
//   rs_data, rt_data         regfile read data, same cycle
//   out_valid / out_ready    execute handshake
//   out_pc .. out_is_load    decoded fields of the instruction in B
// -----------------------------------------------------------------------------
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_command,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [5:0]  out_opcode,
    output logic [5:0]  out_funct,
    output logic [4:0]  out_shamt,
    output logic [31:0] out_rs_val,
    output logic [31:0] out_rt_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_is_load
);

    // Slot A: raw instruction.
    logic        a_v_q, a_v_d;
    logic [31:0] a_pc_q, a_pc_d;
    logic [31:0] a_cmd_q, a_cmd_d;

    // Slot B: decoded instruction.
    logic        b_v_q, b_v_d;
    logic [31:0] b_pc_q, b_pc_d;
    logic [5:0]  b_opcode_q, b_opcode_d;
    logic [5:0]  b_funct_q, b_funct_d;
    logic [4:0]  b_shamt_q, b_shamt_d;
    logic [31:0] b_rs_val_q, b_rs_val_d;
    logic [31:0] b_rt_val_q, b_rt_val_d;
    logic [31:0] b_imm_q, b_imm_d;
    logic [4:0]  b_rd_q, b_rd_d;
    logic        b_we_q, b_we_d;
    logic        b_is_load_q, b_is_load_d;

    // Field extraction from A.
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] target;
    assign opcode = a_cmd_q[31:26];
    assign rs     = a_cmd_q[25:21];
    assign rt     = a_cmd_q[20:16];
    assign rd     = a_cmd_q[15:11];
    assign shamt  = a_cmd_q[10:6];
    assign funct  = a_cmd_q[5:0];
    assign imm16  = a_cmd_q[15:0];
    assign target = a_cmd_q[25:0];

    // Upper nibble of pc+4: adding 4 carries into bit 28 only when
    // pc[27:2] is all ones, so the full 32-bit adder is not needed.
    logic [3:0] pc4_hi;
    assign pc4_hi = a_pc_q[31:28] + {3'b000, &a_pc_q[27:2]};

    logic [31:0] dec_imm;
    logic        has_dest;
    logic [4:0]  dest;
    logic        dec_we;
    logic [4:0]  dec_rd;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case/if leaves it unassigned and infers a latch.
    always_comb begin
        dec_imm = {{16{imm16[15]}}, imm16};
        case (opcode)
            6'h0c, 6'h0d, 6'h0e: dec_imm = {16'h0000, imm16};
            6'h0f:               dec_imm = {imm16, 16'h0000};
            6'h02, 6'h03:        dec_imm = {pc4_hi, target, 2'b00};
            default:             dec_imm = {{16{imm16[15]}}, imm16};
        endcase
    end

    always_comb begin
        has_dest = 1'b0;
        dest     = 5'd0;
        if (opcode == 6'h00 && funct != 6'h08) begin
            has_dest = 1'b1;
            dest     = rd;
        end else if (opcode == 6'h03) begin
            has_dest = 1'b1;
            dest     = 5'd31;
        end else if ((opcode >= 6'h08 && opcode <= 6'h0f) || opcode == 6'h23) begin
            has_dest = 1'b1;
            dest     = rt;
        end
    end

    assign dec_we = has_dest && (dest != 5'd0);
    assign dec_rd = dec_we ? dest : 5'd0;

    // Load-use interlock.
    logic hazard;
`ifdef DECODE_LOAD_STALL_EN
    logic uses_rs, uses_rt;
    assign uses_rs = !(opcode == 6'h02 || opcode == 6'h03 || opcode == 6'h0f);
    assign uses_rt = (opcode == 6'h00) || (opcode == 6'h04) ||
                     (opcode == 6'h05) || (opcode == 6'h2b);
    assign hazard  = b_v_q && b_is_load_q && (b_rd_q != 5'd0) &&
                     ((uses_rs && rs == b_rd_q) || (uses_rt && rt == b_rd_q));
`else
    assign hazard  = 1'b0;
`endif

    // Advance control.
    logic b_free, a_move, a_take;
    assign b_free   = !b_v_q || out_ready;
    assign a_move   = a_v_q && b_free && !hazard;
    assign in_ready = !a_v_q || a_move;
    assign a_take   = in_valid && in_ready;

    assign rs_addr  = a_v_q ? rs : 5'd0;
    assign rt_addr  = a_v_q ? rt : 5'd0;

    always_comb begin
        a_v_d       = a_v_q;
        a_pc_d      = a_pc_q;
        a_cmd_d     = a_cmd_q;
        b_v_d       = b_v_q;
        b_pc_d      = b_pc_q;
        b_opcode_d  = b_opcode_q;
        b_funct_d   = b_funct_q;
        b_shamt_d   = b_shamt_q;
        b_rs_val_d  = b_rs_val_q;
        b_rt_val_d  = b_rt_val_q;
        b_imm_d     = b_imm_q;
        b_rd_d      = b_rd_q;
        b_we_d      = b_we_q;
        b_is_load_d = b_is_load_q;

        if (a_move) begin
            b_v_d       = 1'b1;
            b_pc_d      = a_pc_q;
            b_opcode_d  = opcode;
            b_funct_d   = funct;
            b_shamt_d   = shamt;
            b_rs_val_d  = rs_data;
            b_rt_val_d  = rt_data;
            b_imm_d     = dec_imm;
            b_rd_d      = dec_rd;
            b_we_d      = dec_we;
            b_is_load_d = (opcode == 6'h23);
        end else if (out_ready) begin
            b_v_d = 1'b0;
        end

        if (a_take) begin
            a_v_d   = 1'b1;
            a_pc_d  = in_pc;
            a_cmd_d = in_command;
        end else if (a_move) begin
            a_v_d = 1'b0;
        end

        // Flush wins over any accept or move in the same cycle.
        if (flush) begin
            a_v_d = 1'b0;
            b_v_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, keeping A->B and in->A transfers concurrent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_v_q       <= 1'b0;
            a_pc_q      <= 32'h0;
            a_cmd_q     <= 32'h0;
            b_v_q       <= 1'b0;
            b_pc_q      <= 32'h0;
            b_opcode_q  <= 6'h0;
            b_funct_q   <= 6'h0;
            b_shamt_q   <= 5'h0;
            b_rs_val_q  <= 32'h0;
            b_rt_val_q  <= 32'h0;
            b_imm_q     <= 32'h0;
            b_rd_q      <= 5'h0;
            b_we_q      <= 1'b0;
            b_is_load_q <= 1'b0;
        end else begin
            a_v_q       <= a_v_d;
            a_pc_q      <= a_pc_d;
            a_cmd_q     <= a_cmd_d;
            b_v_q       <= b_v_d;
            b_pc_q      <= b_pc_d;
            b_opcode_q  <= b_opcode_d;
            b_funct_q   <= b_funct_d;
            b_shamt_q   <= b_shamt_d;
            b_rs_val_q  <= b_rs_val_d;
            b_rt_val_q  <= b_rt_val_d;
            b_imm_q     <= b_imm_d;
            b_rd_q      <= b_rd_d;
            b_we_q      <= b_we_d;
            b_is_load_q <= b_is_load_d;
        end
    end

    assign out_valid   = b_v_q;
    assign out_pc      = b_pc_q;
    assign out_opcode  = b_opcode_q;
    assign out_funct   = b_funct_q;
    assign out_shamt   = b_shamt_q;
    assign out_rs_val  = b_rs_val_q;
    assign out_rt_val  = b_rt_val_q;
    assign out_imm     = b_imm_q;
    assign out_rd      = b_rd_q;
    assign out_we      = b_we_q;
    assign out_is_load = b_is_load_q;

endmodule
